// File: rtl/dq_ch_sequencer.sv
// dq_ch_sequencer: steps the Y/Cb/Cr channel order for each MCU of a frame and
// paces blocks from the entropy decoder into deQuant/IDCT.
// Optional feature macro: DQ_SEQ_GRAY_EN adds a 'gray' input. When the latched
// value is 1, each MCU is only its Y blocks.

`ifndef CH
`define CH 2
`endif

module dq_ch_sequencer #(
    parameter int MCU_W = 16,
    parameter int CH_W  = $clog2(`CH+1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       y_per_mcu,
    input  logic [MCU_W-1:0] mcu_total,
    input  logic             blk_valid,
    input  logic             dq_ready,
`ifdef DQ_SEQ_GRAY_EN
    input  logic             gray,
`endif
    output logic             blk_ready,
    output logic [CH_W-1:0]  ch_out,
    output logic [MCU_W-1:0] mcu_idx,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN_Y,
        ST_RUN_CB,
        ST_RUN_CR,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [1:0]       r_ycnt;
    logic [MCU_W-1:0] r_mcu_idx;
    logic [2:0]       r_ypm;
    logic [MCU_W-1:0] r_mcu_total;
    logic [CH_W-1:0]  r_ch;
    logic             r_busy;
    logic             r_done;

    logic             w_run;
    logic             w_fire;
    logic [1:0]       w_ylast;
    logic             w_last_mcu;
    logic             w_gray;

`ifdef DQ_SEQ_GRAY_EN
    logic             r_gray;

    // Latched grayscale mode; cleared by reset, loaded only on an accepted start.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_gray <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_gray <= gray;
        end
    end

    assign w_gray = r_gray;
`else
    assign w_gray = 1'b0;
`endif

    assign w_run      = (r_state == ST_RUN_Y) || (r_state == ST_RUN_CB) || (r_state == ST_RUN_CR);
    assign blk_ready  = dq_ready && w_run;
    assign w_fire     = blk_valid && blk_ready;
    // Unsupported Y counts (0, 3, 5..7) collapse to one Y block per MCU.
    assign w_ylast    = (r_ypm == 3'd2) ? 2'd1 : (r_ypm == 3'd4) ? 2'd3 : 2'd0;
    assign w_last_mcu = (r_mcu_idx == (r_mcu_total - MCU_W'(1)));

    assign ch_out     = r_ch;
    assign mcu_idx    = r_mcu_idx;
    assign busy       = r_busy;
    assign frame_done = r_done;

    // Sequencer FSM; ch_out/busy/frame_done are registered alongside each transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ycnt      <= '0;
            r_mcu_idx   <= '0;
            r_ypm       <= '0;
            r_mcu_total <= '0;
            r_ch        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_ch   <= '0;
                    if (start) begin
                        r_ypm       <= y_per_mcu;
                        r_mcu_total <= mcu_total;
                        r_ycnt      <= '0;
                        r_mcu_idx   <= '0;
                        r_busy      <= 1'b1;
                        if (mcu_total == '0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN_Y;
                        end
                    end
                end
                ST_RUN_Y: begin
                    if (w_fire) begin
                        if (r_ycnt == w_ylast) begin
                            r_ycnt <= '0;
                            if (w_gray) begin
                                // Grayscale MCU ends on its last Y block.
                                if (w_last_mcu) begin
                                    r_state <= ST_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_mcu_idx <= r_mcu_idx + MCU_W'(1);
                                end
                                r_ch <= '0;
                            end else begin
                                r_state <= ST_RUN_CB;
                                r_ch    <= CH_W'(1);
                            end
                        end else begin
                            r_ycnt <= r_ycnt + 2'd1;
                        end
                    end
                end
                ST_RUN_CB: begin
                    if (w_fire) begin
                        r_state <= ST_RUN_CR;
                        r_ch    <= CH_W'(2);
                    end
                end
                ST_RUN_CR: begin
                    if (w_fire) begin
                        r_ch <= '0;
                        if (w_last_mcu) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_RUN_Y;
                            r_mcu_idx <= r_mcu_idx + MCU_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ch    <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ch    <= '0;
                end
            endcase
        end
    end

endmodule
